// File: rtl/time_scale_mch.sv
// -----------------------------------------------------------------------------
// time_scale_mch
//
// Multi-channel time-scale generator. Each channel owns a code-rate NCO
// (phase accumulator), a chip counter, an epoch counter and an epoch
// interrupt divider. A single snapshot strobe latches phase/chip/eph of every
// channel in the same cycle, so software reads a coherent cross-channel time.
//
// Ports (channel i occupies slice [i*W +: W] of every packed bus):
//   clk, resetn                 clock, asynchronous active-low reset
//   en[i]                       channel run enable
//   code_rate                   per-channel NCO phase increment
//   chip_max / epoch_max        last chip / epoch index before wrap
//   intr_eph                    epochs per interrupt (0 disables)
//   load[i] + load_phase/chip/eph   one-cycle load of channel state
//   snap                        one-cycle strobe: snapshot all channels
//   irq_clr[i]                  clear sticky interrupt
//   snap_phase/chip/eph         snapshot registers
//   snap_valid                  one-cycle pulse when snapshot updated
//   chip_stb / epoch_stb        one-cycle boundary pulses, aligned with the
//                               new chip/eph value becoming visible
//   irq                         sticky interrupt pending
// -----------------------------------------------------------------------------
module time_scale_mch #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 32,
    parameter int CHIP_W  = 16,
    parameter int EPH_W   = 16,
    parameter int INTR_W  = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH*PHASE_W-1:0] code_rate,
    input  logic [N_CH*CHIP_W-1:0]  chip_max,
    input  logic [N_CH*EPH_W-1:0]   epoch_max,
    input  logic [N_CH*INTR_W-1:0]  intr_eph,
    input  logic [N_CH-1:0]         load,
    input  logic [N_CH*PHASE_W-1:0] load_phase,
    input  logic [N_CH*CHIP_W-1:0]  load_chip,
    input  logic [N_CH*EPH_W-1:0]   load_eph,
    input  logic                    snap,
    input  logic [N_CH-1:0]         irq_clr,
    output logic [N_CH*PHASE_W-1:0] snap_phase,
    output logic [N_CH*CHIP_W-1:0]  snap_chip,
    output logic [N_CH*EPH_W-1:0]   snap_eph,
    output logic                    snap_valid,
    output logic [N_CH-1:0]         chip_stb,
    output logic [N_CH-1:0]         epoch_stb,
    output logic [N_CH-1:0]         irq
);

    logic snap_valid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap;
        end
    end

    assign snap_valid = snap_valid_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [PHASE_W-1:0] phase_q, phase_d;
        logic [CHIP_W-1:0]  chip_q, chip_d;
        logic [EPH_W-1:0]   eph_q, eph_d;
        logic [INTR_W-1:0]  div_q, div_d;
        logic               chip_stb_q, chip_stb_d;
        logic               epoch_stb_q, epoch_stb_d;
        logic               irq_q, irq_d;
        logic               irq_set;
        logic [PHASE_W-1:0] snap_phase_q;
        logic [CHIP_W-1:0]  snap_chip_q;
        logic [EPH_W-1:0]   snap_eph_q;

        // One extra bit on the sum and on the divider increment so the carry
        // and the divider compare never alias through wrap-around.
        logic [PHASE_W:0]   sum;
        logic [INTR_W:0]    div_inc;

        logic [PHASE_W-1:0] rate;
        logic [CHIP_W-1:0]  cmax;
        logic [EPH_W-1:0]   emax;
        logic [INTR_W-1:0]  imax;

        assign rate = code_rate[gi*PHASE_W +: PHASE_W];
        assign cmax = chip_max[gi*CHIP_W +: CHIP_W];
        assign emax = epoch_max[gi*EPH_W +: EPH_W];
        assign imax = intr_eph[gi*INTR_W +: INTR_W];

        always_comb begin
            phase_d     = phase_q;
            chip_d      = chip_q;
            eph_d       = eph_q;
            div_d       = div_q;
            chip_stb_d  = 1'b0;
            epoch_stb_d = 1'b0;
            irq_set     = 1'b0;
            sum         = {1'b0, phase_q} + {1'b0, rate};
            div_inc     = {1'b0, div_q} + 1'b1;

            if (load[gi]) begin
                phase_d = load_phase[gi*PHASE_W +: PHASE_W];
                chip_d  = load_chip[gi*CHIP_W +: CHIP_W];
                eph_d   = load_eph[gi*EPH_W +: EPH_W];
                div_d   = '0;
            end else if (en[gi]) begin
                phase_d = sum[PHASE_W-1:0];
                if (sum[PHASE_W]) begin
                    chip_stb_d = 1'b1;
                    // ">=" lets an out-of-range loaded chip/eph wrap at its
                    // next boundary instead of running through the full range.
                    if (chip_q >= cmax) begin
                        chip_d      = '0;
                        epoch_stb_d = 1'b1;
                        eph_d       = (eph_q >= emax) ? '0 : eph_q + 1'b1;
                        if (imax == '0) begin
                            div_d = '0;
                        end else if (div_inc >= {1'b0, imax}) begin
                            div_d   = '0;
                            irq_set = 1'b1;
                        end else begin
                            div_d = div_inc[INTR_W-1:0];
                        end
                    end else begin
                        chip_d = chip_q + 1'b1;
                    end
                end
            end

            // Set has priority over a coincident clear.
            irq_d = irq_set | (irq_q & ~irq_clr[gi]);
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                phase_q      <= '0;
                chip_q       <= '0;
                eph_q        <= '0;
                div_q        <= '0;
                chip_stb_q   <= 1'b0;
                epoch_stb_q  <= 1'b0;
                irq_q        <= 1'b0;
                snap_phase_q <= '0;
                snap_chip_q  <= '0;
                snap_eph_q   <= '0;
            end else begin
                phase_q     <= phase_d;
                chip_q      <= chip_d;
                eph_q       <= eph_d;
                div_q       <= div_d;
                chip_stb_q  <= chip_stb_d;
                epoch_stb_q <= epoch_stb_d;
                irq_q       <= irq_d;
                // Captures the pre-edge state, so a coincident load or
                // advance is not reflected in the snapshot.
                if (snap) begin
                    snap_phase_q <= phase_q;
                    snap_chip_q  <= chip_q;
                    snap_eph_q   <= eph_q;
                end
            end
        end

        assign snap_phase[gi*PHASE_W +: PHASE_W] = snap_phase_q;
        assign snap_chip[gi*CHIP_W +: CHIP_W]    = snap_chip_q;
        assign snap_eph[gi*EPH_W +: EPH_W]       = snap_eph_q;
        assign chip_stb[gi]                      = chip_stb_q;
        assign epoch_stb[gi]                     = epoch_stb_q;
        assign irq[gi]                           = irq_q;
    end

endmodule

// File: tb/tb_time_scale_mch.sv
module tb_time_scale_mch;
    localparam int N  = 4;
    localparam int PW = 32;
    localparam int CW = 16;
    localparam int EW = 16;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    en, load, irq_clr;
    logic            snap;
    logic [N*PW-1:0] code_rate, load_phase;
    logic [N*CW-1:0] chip_max, load_chip;
    logic [N*EW-1:0] epoch_max, load_eph;
    logic [N*IW-1:0] intr_eph;
    logic [N*PW-1:0] snap_phase;
    logic [N*CW-1:0] snap_chip;
    logic [N*EW-1:0] snap_eph;
    logic            snap_valid;
    logic [N-1:0]    chip_stb, epoch_stb, irq;

    always #5 clk = ~clk;

    time_scale_mch dut (
        .clk(clk), .resetn(resetn), .en(en), .code_rate(code_rate),
        .chip_max(chip_max), .epoch_max(epoch_max), .intr_eph(intr_eph),
        .load(load), .load_phase(load_phase), .load_chip(load_chip),
        .load_eph(load_eph), .snap(snap), .irq_clr(irq_clr),
        .snap_phase(snap_phase), .snap_chip(snap_chip), .snap_eph(snap_eph),
        .snap_valid(snap_valid), .chip_stb(chip_stb), .epoch_stb(epoch_stb),
        .irq(irq)
    );

    // Expected content of the snapshot registers plus the strobe/irq vectors
    // visible in the cycle snap_valid is high.
    typedef struct {
        string        name;
        logic [127:0] ph;
        logic [63:0]  ch;
        logic [63:0]  ep;
        logic [3:0]   cs;
        logic [3:0]   es;
        logic [3:0]   iq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   j;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [127:0] ph, input logic [63:0] ch,
                                input logic [63:0] ep, input logic [3:0] cs,
                                input logic [3:0] es, input logic [3:0] iq);
        exp_t e;
        e.name = nm; e.ph = ph; e.ch = ch; e.ep = ep; e.cs = cs; e.es = es; e.iq = iq;
        return e;
    endfunction

    // All channels at rate 2^31, chip_max=3, epoch_max=1, k edges after a
    // zero state: phase toggles, chip advances every 2 edges, eph every 8.
    // Strobes are those of the following edge k+1.
    function automatic exp_t mk_half(input string nm, input int k, input logic [3:0] iq);
        logic [31:0] p;
        logic [15:0] c, ep;
        p  = (k % 2 == 1) ? 32'h8000_0000 : 32'h0;
        c  = 16'((k / 2) % 4);
        ep = 16'((k / 8) % 2);
        return mk(nm, {4{p}}, {4{c}}, {4{ep}},
                  ((k + 1) % 2 == 0) ? 4'hF : 4'h0,
                  ((k + 1) % 8 == 0) ? 4'hF : 4'h0, iq);
    endfunction

    // Monitor: every snap_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (snap_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_snap_valid: got snap_valid=1 want 0");
            end else begin
                e = sb.pop_front();
                cmp({e.name, ".phase"}, snap_phase, e.ph);
                cmp({e.name, ".chip"}, {64'h0, snap_chip}, {64'h0, e.ch});
                cmp({e.name, ".eph"}, {64'h0, snap_eph}, {64'h0, e.ep});
                cmp({e.name, ".stb_irq"}, {116'h0, chip_stb, epoch_stb, irq},
                    {116'h0, e.cs, e.es, e.iq});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        j++;
    endtask

    task automatic run_to(input int n);
        while (j < n) cyc();
    endtask

    task automatic reload();
        load = 4'hF; load_phase = '0; load_chip = '0; load_eph = '0;
        cyc();
        load = 4'h0;
        j = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending snapshots want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        resetn = 1'b0; en = '0; load = '0; irq_clr = '0; snap = 1'b0;
        code_rate = {4{32'h8000_0000}}; chip_max = {4{16'd3}}; epoch_max = {4{16'd1}};
        intr_eph = '0; load_phase = '0; load_chip = '0; load_eph = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        j = 0;

        // Reset state
        cmp("reset.phase", snap_phase, 128'h0);
        cmp("reset.chip", {64'h0, snap_chip}, 128'h0);
        cmp("reset.eph", {64'h0, snap_eph}, 128'h0);
        cmp("reset.flags", {115'h0, snap_valid, chip_stb, epoch_stb, irq}, 128'h0);

        // Rate 2^31 sweep: snapshot every cycle
        en = 4'hF; snap = 1'b1;
        for (int k = 0; k < 18; k++) begin
            sb.push_back(mk_half("rate_half", k, 4'h0));
            cyc();
        end
        snap = 1'b0;

        // Interrupt every 3 epochs
        intr_eph = {4{8'd3}};
        reload();
        snap = 1'b1;
        for (int k = 0; k < 28; k++) begin
            sb.push_back(mk_half("irq_rise", k, (k + 1 >= 24) ? 4'hF : 4'h0));
            cyc();
        end
        irq_clr = 4'hF;
        sb.push_back(mk_half("irq_clr", 28, 4'h0));
        cyc();
        irq_clr = 4'h0; snap = 1'b0;
        run_to(47);
        irq_clr = 4'hF; snap = 1'b1;
        sb.push_back(mk_half("irq_set_wins", 47, 4'hF));
        cyc();
        irq_clr = 4'h0;
        sb.push_back(mk_half("irq_sticky", 48, 4'hF));
        cyc();
        snap = 1'b0;

        // Interrupt disabled
        intr_eph = '0; irq_clr = 4'hF;
        cyc();
        irq_clr = 4'h0;
        run_to(132);
        snap = 1'b1;
        sb.push_back(mk_half("irq_off_a", 132, 4'h0));
        cyc();
        snap = 1'b0;
        run_to(135);
        snap = 1'b1;
        sb.push_back(mk_half("irq_off_b", 135, 4'h0));
        cyc();
        snap = 1'b0;
        cyc();

        // Load beats a pending carry; out-of-range chip wraps at next carry
        load = 4'hF; load_phase = '0; load_chip = {4{16'd10}}; load_eph = '0; snap = 1'b1;
        e = mk_half("load_pre", j, 4'h0);
        e.cs = 4'h0; e.es = 4'h0;
        sb.push_back(e);
        cyc();
        load = 4'h0; j = 0;
        sb.push_back(mk("load_vis", 128'h0, {4{16'd10}}, 64'h0, 4'h0, 4'h0, 4'h0));
        cyc();
        sb.push_back(mk("load_wrap", {4{32'h8000_0000}}, {4{16'd10}}, 64'h0, 4'hF, 4'hF, 4'h0));
        cyc();
        sb.push_back(mk("load_after", 128'h0, 64'h0, {4{16'd1}}, 4'h0, 4'h0, 4'h0));
        cyc();
        snap = 1'b0;

        // Coherent snapshot across channels with distinct rates
        code_rate = {32'd4, 32'd3, 32'd2, 32'd1};
        reload();
        run_to(100);
        snap = 1'b1;
        sb.push_back(mk("coherent", {32'd400, 32'd300, 32'd200, 32'd100}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        snap = 1'b0;
        cyc();
        cmp("snap_valid_once", {127'h0, snap_valid}, 128'h0);

        // Snap coincident with a ch0 load
        load = 4'b0001; load_phase = {96'h0, 32'h0000_DEAD}; snap = 1'b1;
        sb.push_back(mk("snap_load_pre", {32'd408, 32'd306, 32'd204, 32'd102}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        load = 4'h0;
        sb.push_back(mk("snap_load_vis", {32'd412, 32'd309, 32'd206, 32'h0000_DEAD}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        sb.push_back(mk("snap_load_run", {32'd416, 32'd312, 32'd208, 32'h0000_DEAE}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        snap = 1'b0;

        // Per-channel disable
        reload();
        run_to(10);
        en = 4'b1101;
        run_to(20);
        snap = 1'b1;
        sb.push_back(mk("ch1_frozen", {32'd80, 32'd60, 32'd20, 32'd20}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        snap = 1'b0;
        drain();

        // Asynchronous reset mid-count
        #3;
        resetn = 1'b0;
        #1;
        cmp("async_reset.phase", snap_phase, 128'h0);
        cmp("async_reset.flags", {115'h0, snap_valid, chip_stb, epoch_stb, irq}, 128'h0);
        en = 4'hF;
        @(negedge clk);
        resetn = 1'b1;
        j = 0;
        run_to(5);
        snap = 1'b1;
        sb.push_back(mk("after_reset", {32'd20, 32'd15, 32'd10, 32'd5}, 64'h0, 64'h0,
                        4'h0, 4'h0, 4'h0));
        cyc();
        snap = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_scale_mch.md
# time_scale_mch

Multi-channel time-scale generator: the parametrised successor of the single-channel TIME_SCALE block served by `regs_file`. Each of N_CH channels runs its own code-rate NCO, chip counter and epoch counter, plus a programmable epoch interrupt. A global snapshot strobe latches all channels in the same cycle, giving coherent cross-channel time readout. Configuration comes from the register file, snapshot outputs go back to it, and strobes feed correlator and timing logic.

## Interface
- N_CH, 4: number of channels
- PHASE_W, 32: NCO phase accumulator width
- CHIP_W, 16: chip counter width
- EPH_W, 16: epoch counter width
- INTR_W, 8: interrupt epoch-divider width
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- en  in  N_CH  per-channel run enable
- code_rate  in  N_CH*PHASE_W  per-channel phase increment, channel i at bits [i*PHASE_W +: PHASE_W]
- chip_max  in  N_CH*CHIP_W  last chip index before wrap
- epoch_max  in  N_CH*EPH_W  last epoch index before wrap
- intr_eph  in  N_CH*INTR_W  epochs per interrupt; 0 disables the interrupt
- load  in  N_CH  one-cycle strobe: load the phase/chip/eph values
- load_phase / load_chip / load_eph  in  N_CH*PHASE_W / N_CH*CHIP_W / N_CH*EPH_W  load values
- snap  in  1  one-cycle strobe: snapshot all channels
- irq_clr  in  N_CH  clears a pending interrupt
- snap_phase / snap_chip / snap_eph  out  N_CH*PHASE_W / N_CH*CHIP_W / N_CH*EPH_W  snapshot registers
- snap_valid  out  1  one-cycle pulse: snapshot updated
- chip_stb  out  N_CH  one-cycle pulse per chip boundary
- epoch_stb  out  N_CH  one-cycle pulse per epoch boundary
- irq  out  N_CH  sticky interrupt pending

## Operation
- Per channel i, the following priority applies at each edge:
  1. load[i]: phase, chip and eph take their load values; the interrupt divider counter clears; no strobes are generated.
  2. Otherwise, if en[i]: {carry, phase} = phase + code_rate, computed at PHASE_W+1 bits with the carry discarded from phase.
     - On carry: if chip >= chip_max, chip becomes 0 and an epoch boundary occurs; else chip increments.
  3. Otherwise (en[i]=0): all state holds and no strobes are generated.
- On an epoch boundary:
  - If eph >= epoch_max, eph becomes 0; else eph increments.
  - The ">=" compare guarantees that an out-of-range loaded chip or eph wraps to 0 at its next boundary.
- Interrupt divider:
  - The INTR_W-bit counter increments on each epoch boundary.
  - When the counter reaches intr_eph (intr_eph != 0), it clears to 0 and irq[i] sets.
  - With intr_eph == 0, the counter holds at 0 and irq never sets.
- irq[i] is sticky and clears on irq_clr[i]. If set and clear occur in the same cycle, set wins.
- Snapshot: snap captures the current (pre-edge) phase/chip/eph of all channels into the snap_* registers.
  - snap_valid pulses for one cycle.
  - When snap coincides with load or advance, the snapshot holds the value from before that edge.
- Configuration inputs (code_rate, chip_max, epoch_max, intr_eph) are sampled every cycle. A change takes effect on the next advance and is not otherwise synchronised.

## Timing
- Reset values are all zero: phase, chip, eph, divider counters, snap_*, snap_valid, chip_stb, epoch_stb, irq.
- chip_stb[i] is registered: it is high in the cycle during which the new chip value is visible.
- epoch_stb[i] is aligned the same way, and is always coincident with chip_stb[i] at that boundary.
- irq[i] rises in the same cycle as the epoch_stb that triggers it.
- snap_valid and the new snap_* values appear 1 cycle after snap is sampled.
- A load value is visible on the next cycle. The first advance after a load occurs on the following edge if en=1.
- Reset is asynchronous:
  - Asserting it mid-count zeroes all state immediately.
  - Outputs hold at zero until the first edge after deassertion.
- All channels are independent: no shared state except the snap strobe.

## Test plan
- Reset / rate 2^31 (PHASE_W=32), chip_max=3, epoch_max=1, en=1:
  - After reset, all outputs are 0.
  - chip_stb fires every 2 cycles and chip cycles 1,2,3,0.
  - epoch_stb fires every 8 cycles; eph alternates 1,0.
- Interrupt, intr_eph=3:
  - irq rises with the 3rd epoch_stb and stays high.
  - irq_clr drops it on the next edge.
  - Set and clear asserted in the same cycle: irq stays 1.
  - With intr_eph=0, irq stays 0 across 10 epochs.
- Load priority:
  - load with en=1, load_chip=10 while chip_max=3: chip=10 next cycle with no chip_stb.
  - At the next carry, chip=0 and epoch_stb fires.
- Coherent snapshot: channels 0..3 with rates 1, 2, 3, 4, snap at cycle 100:
  - snap_phase equals {100, 200, 300, 400} minus any carries (none at these values).
  - snap_valid is high only at cycle 101.
- Snap coincident with load on ch0 (load_phase=0xDEAD): snapshot holds the pre-load phase; phase reads 0xDEAD afterwards.
- Disable and reset:
  - en[1]=0 freezes ch1 while ch0 keeps counting.
  - Asserting resetn=0 mid-epoch asynchronously clears all state; counting resumes from 0 after release.
